// File: rtl/yl3_scroller.sv
// Scrolling text source for the YL-3 8-digit driver: message buffer, 8-char window, LOAD/READY handshake.
// Optional bounce scrolling is enabled by defining YL3_SCROLL_BOUNCE_EN (default build: wrap scrolling).
module yl3_scroller #(
   parameter int unsigned MAX_LEN     = 32,
   parameter int unsigned STEP_CYCLES = 12500000,
   parameter int unsigned CNT_W       = 24,
   localparam int unsigned AW         = $clog2(MAX_LEN)
) (
   input  logic          CLK,
   input  logic          nRST,
   input  logic          ENABLE,
   input  logic          RESTART,
   input  logic          MSG_WE,
   input  logic [AW-1:0] MSG_ADDR,
   input  logic [7:0]    MSG_CHAR,
   input  logic [AW:0]   MSG_LEN,
   input  logic          READY,
   output logic [63:0]   DATA,
   output logic          LOAD,
   output logic          BUSY
);

   localparam logic [63:0] BLANK = {8{8'h20}};

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_READY} state_t;

   state_t            state, state_next;
   logic [1:0]        wb_cnt, wb_cnt_next;
   logic              issue;

   logic [7:0]        msg_mem [MAX_LEN];
   logic [AW:0]       len, len_in;
   logic [AW:0]       pos, pos_adv, start_pos;
   logic [CNT_W-1:0]  cnt;
   logic              pending;
   logic              tick;
   logic [63:0]       data_q;
   logic [63:0]       window;

   // Message buffer has no reset; contents survive nRST.
   always_ff @(posedge CLK) begin
      if (MSG_WE) msg_mem[MSG_ADDR] <= MSG_CHAR;
   end

   assign len_in = (MSG_LEN > (AW+1)'(MAX_LEN)) ? (AW+1)'(MAX_LEN) : MSG_LEN;
   assign tick   = ENABLE && (cnt == CNT_W'(STEP_CYCLES - 1));

   // Virtual index v = pos+k; message occupies v in [8, 8+len), spaces elsewhere.
   always_comb begin
      logic [AW+1:0] v;
      window = BLANK;
      for (int unsigned k = 0; k < 8; k++) begin
         v = {1'b0, pos} + (AW+2)'(k);
         if (v >= (AW+2)'(8) && v < ({1'b0, len} + (AW+2)'(8)))
            window[63-8*k -: 8] = msg_mem[AW'(v - (AW+2)'(8))];
      end
   end

`ifdef YL3_SCROLL_BOUNCE_EN
   logic        dir_up, dir_next;
   logic [AW:0] lo, hi;

   assign lo        = (len < (AW+1)'(8)) ? len : (AW+1)'(8);
   assign hi        = (len < (AW+1)'(8)) ? (AW+1)'(8) : len;
   assign start_pos = (len_in < (AW+1)'(8)) ? len_in : (AW+1)'(8);

   // Reversal happens on the frame after an end value, so each end is shown exactly once.
   always_comb begin
      pos_adv  = pos;
      dir_next = dir_up;
      if (lo != hi) begin
         if (dir_up) begin
            if (pos >= hi) begin
               pos_adv  = pos - 1'b1;
               dir_next = 1'b0;
            end else begin
               pos_adv  = pos + 1'b1;
            end
         end else begin
            if (pos <= lo) begin
               pos_adv  = pos + 1'b1;
               dir_next = 1'b1;
            end else begin
               pos_adv  = pos - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)        dir_up <= 1'b1;
      else if (RESTART) dir_up <= 1'b1;
      else if (issue)   dir_up <= dir_next;
   end
`else
   assign start_pos = '0;

   always_comb begin
      if (len == '0 || pos == len + (AW+1)'(7)) pos_adv = '0;
      else                                      pos_adv = pos + 1'b1;
   end
`endif

   // Later assignments win: RESTART over frame issue over step tick.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         len     <= '0;
         pos     <= '0;
         cnt     <= '0;
         pending <= 1'b1;
         data_q  <= BLANK;
      end else begin
         if (ENABLE) cnt <= tick ? '0 : cnt + 1'b1;
         if (tick) pending <= 1'b1;
         if (issue) begin
            data_q  <= window;
            pos     <= pos_adv;
            pending <= 1'b0;
         end
         if (RESTART) begin
            len     <= len_in;
            pos     <= start_pos;
            cnt     <= '0;
            pending <= 1'b1;
         end
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state  <= IDLE;
         wb_cnt <= '0;
      end else begin
         state  <= state_next;
         wb_cnt <= wb_cnt_next;
      end
   end

   always_comb begin
      state_next  = state;
      wb_cnt_next = wb_cnt;
      issue       = 1'b0;
      case (state)
         IDLE: begin
            if (pending && READY && !RESTART) begin
               issue      = 1'b1;
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            state_next  = WAIT_BUSY;
            wb_cnt_next = '0;
         end
         WAIT_BUSY: begin
            if (!READY || wb_cnt == 2'd3) state_next  = WAIT_READY;
            else                          wb_cnt_next = wb_cnt + 1'b1;
         end
         WAIT_READY: begin
            if (READY) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign DATA = data_q;
   assign LOAD = (state == ISSUE);
   assign BUSY = pending || (state != IDLE);

endmodule

// File: doc/yl3_scroller.md
Name: yl3_scroller

Overview:
- Upstream text source for the YL-3 8-digit display driver. Holds a writable ASCII message buffer.
- Generates an 8-character window over the message, stepping once per STEP_CYCLES.
- Hands each window to the driver as a 64-bit DATA word through the driver's LOAD/READY handshake.
- Replaces hand-built per-frame string tables in top-level logic.

Parameters:
- MAX_LEN, 32: message buffer depth in characters, power of two, at least 8. Localparam AW = clog2(MAX_LEN).
- STEP_CYCLES, 12500000: CLK cycles between scroll steps (0.25 s at 50 MHz). Must be at least 2.
- CNT_W, 24: width of the step counter. Must satisfy 2^CNT_W > STEP_CYCLES.

Ports:
- CLK  in  1  system clock, rising-edge.
- nRST  in  1  asynchronous active-low reset.
- ENABLE  in  1  1 = step counter runs; 0 = counter frozen, current frame held.
- RESTART  in  1  single-cycle pulse: latch MSG_LEN, return to start position, request a frame.
- MSG_WE  in  1  buffer write strobe.
- MSG_ADDR  in  AW  buffer write address.
- MSG_CHAR  in  8  ASCII byte to write.
- MSG_LEN  in  AW+1  message length, sampled only on RESTART.
- READY  in  1  driver idle/accepting, from the YL-3 driver.
- DATA  out  64  window; [63:56] is the leftmost digit, [7:0] the rightmost.
- LOAD  out  1  single-cycle frame strobe to the driver.
- BUSY  out  1  high when a frame is pending or a handshake is in progress.

Behaviour:
- Reset (nRST=0, asynchronous):
  - DATA=64'h2020202020202020, LOAD=0, len=0, pos=0, cnt=0, state=IDLE, pending=1.
  - The buffer is not reset.
- Buffer: synchronous write on MSG_WE. A write never triggers a frame by itself. Writes are legal in any state; the new content appears on the next issued frame.
- Length: on RESTART, len = min(MSG_LEN, MAX_LEN).
- Window, combinational from pos:
  - Virtual index v = pos+k for k=0..7.
  - Character = buf[v-8] when 8 <= v < 8+len; otherwise 0x20 (space).
  - Character k goes to DATA[63-8k -: 8].
- Step counter:
  - When ENABLE=1, cnt increments each cycle.
  - At cnt == STEP_CYCLES-1, cnt goes to 0 and pending is set (tick).
  - Ticks coalesce: a tick while pending is already set is lost; pos never advances more than once per issued frame.
- RESTART:
  - cnt=0, pending=1, pos = start position (see below).
  - Has priority over a tick in the same cycle.
  - During a handshake it takes effect immediately; the new frame issues after the current handshake completes.
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_READY.
  - IDLE: if pending and READY=1, latch DATA from window(pos), advance pos, clear pending, go to ISSUE.
  - ISSUE: LOAD=1 for exactly this cycle; go to WAIT_BUSY.
  - WAIT_BUSY: exit on READY=0, or after 4 cycles in this state; go to WAIT_READY.
  - WAIT_READY: wait for READY=1; go to IDLE.
  - LOAD=1 only in ISSUE. BUSY = pending OR state != IDLE.
- Advance (wrap mode, default):
  - pos = (pos == len+7) ? 0 : pos+1. Start position is 0.
  - len=0 holds pos at 0, giving a blank display.
- Latency: RESTART with READY=1 gives LOAD 2 cycles later, with DATA valid in the same cycle as LOAD.
- Reset mid-handshake: LOAD drops immediately, and a blank frame is issued once READY=1 after reset release.

Optional Feature:
- Macro: YL3_SCROLL_BOUNCE_EN.
- Defined (bounce mode):
  - lo = min(len,8), hi = max(len,8); start pos = lo, direction = up.
  - pos moves ±1 per frame and reverses at hi and lo; the end value is shown once.
  - lo == hi holds pos constant.
- Undefined: wrap mode as in Behaviour; no direction register is synthesised.

Test Plan:
- Bench uses STEP_CYCLES=4 and a model driver that drops READY for 10 cycles after each LOAD.
- Reset release, READY=1 -> one LOAD with DATA=64'h2020202020202020, then no further LOAD while ENABLE=0.
- Wrap mode: write "HELLO", MSG_LEN=5, RESTART, ENABLE=1 -> successive DATA:
  - 2020202020202020
  - 2020202020202048
  - 2020202020204845
  - ...
  - pos 12 "O       " = 4F20202020202020
  - then back to all spaces.
- Bounce mode, same message -> frame sequence "   HELLO", "  HELLO ", " HELLO  ", "HELLO   ", " HELLO  ", "  HELLO ", "   HELLO", repeating.
- READY held 0 for 20 ticks, then released -> exactly one LOAD; pos advanced by exactly one frame.
- MSG_LEN=40 with MAX_LEN=32, RESTART -> len=32; wrap after pos 39.
- Reset asserted in WAIT_READY -> LOAD=0 and DATA=all spaces asynchronously; recovery matches the first scenario.
